// File: rtl/rptr_sync_wfull.sv
// rptr_sync_wfull: brings the Gray-coded read pointer of an async FIFO into
// the write clock domain and derives fill level, full / almost-full flags and
// sticky overflow / pointer-error flags. Outputs report "full" until the
// synchroniser pipeline holds valid data after reset.

module rptr_sync_wfull #(
  parameter int ADDR      = 2,
  parameter int AF_THRESH = 3
) (
  input  logic          wclk,
  input  logic          wreset,
  input  logic [ADDR:0] rptr_gray,
  input  logic [ADDR:0] write_ptr,
  input  logic          wen,
  input  logic          clr_err,
  output logic [ADDR:0] rptr_bin,
  output logic [ADDR:0] level,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic          ptr_err
);

  localparam int P = ADDR + 1;

  // Level equal to the FIFO depth; anything above it is an impossible state.
  localparam logic [ADDR:0] DEPTH  = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_LVL = P'(AF_THRESH);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    wcnt;
  logic [1:0]    wcnt_next;

  logic [ADDR:0] s1;
  logic [ADDR:0] s2;
  logic [ADDR:0] s3;
  logic [ADDR:0] bin_dec;
  logic [ADDR:0] diff;
  logic [ADDR:0] gray_delta;
  logic          run;
  logic          gray_bad;
  logic          level_bad;
  logic          ptr_set;

  // Two-flop synchroniser plus one history stage for Gray-step checking.
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= rptr_gray;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < P; i++) begin
      bin_dec[i] = ^(s2 >> i);
    end
  end

  // Register the decoded pointer so downstream arithmetic sees a clean value.
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      rptr_bin <= '0;
    end else begin
      rptr_bin <= bin_dec;
    end
  end

  // Warm-up state register and edge counter.
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      state <= WARMUP;
      wcnt  <= 2'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Stay in WARMUP until the synchroniser pipeline has been filled.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    case (state)
      WARMUP: begin
        wcnt_next = wcnt + 2'd1;
        if (wcnt == 2'd2) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = WARMUP;
      end
    endcase
  end

  // Level and flags; a not-yet-ready block reports full so writers back off.
  always_comb begin
    run         = (state == RUN);
    diff        = write_ptr - rptr_bin;
    level       = run ? diff : '0;
    full        = !run ||
                  ((write_ptr[ADDR] != rptr_bin[ADDR]) &&
                   (write_ptr[ADDR-1:0] == rptr_bin[ADDR-1:0]));
    almost_full = !run || (diff >= AF_LVL);
  end

  // A legal Gray step changes at most one bit, so the delta must be a power of two or zero.
  always_comb begin
    gray_delta = s2 ^ s3;
    gray_bad   = (gray_delta & (gray_delta - 1'b1)) != '0;
    level_bad  = diff > DEPTH;
    ptr_set    = run && (gray_bad || level_bad);
  end

  // Sticky overflow: a set on the same edge as a clear takes priority.
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      overflow <= 1'b0;
    end else if (wen && full) begin
      overflow <= 1'b1;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end
  end

  // Sticky pointer error, same set-over-clear priority as overflow.
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      ptr_err <= 1'b0;
    end else if (ptr_set) begin
      ptr_err <= 1'b1;
    end else if (clr_err) begin
      ptr_err <= 1'b0;
    end
  end

endmodule
